// File: rtl/d7s_pkg.sv
// Shared definitions for the 3-digit BCD count / 7-segment display path.
// Digit and packed-value types plus the BCD validity test used on parallel loads.
package d7s_pkg;

    localparam int BCD_DIGITS = 3;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [11:0] bcd3_t;

    localparam bcd_digit_t DIGIT_MAX = 4'd9;

    // True when every nibble of the packed value is a legal decimal digit.
    function automatic logic is_valid_bcd(bcd3_t v);
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] > DIGIT_MAX) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell of the ripple chain: computes the digit's next value for an
// increment or decrement and reports carry (limit->0) or borrow (0->limit).
module bcd_digit
    import d7s_pkg::*;
(
    input  bcd_digit_t d,
    input  logic       inc,
    input  logic       dec,
    input  bcd_digit_t limit,
    output bcd_digit_t q,
    output logic       carry,
    output logic       borrow
);

    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
        q      = d;
        carry  = 1'b0;
        borrow = 1'b0;
        if (inc) begin
            if (d >= limit) begin
                q     = '0;
                carry = 1'b1;
            end else begin
                q = d + bcd_digit_t'(1);
            end
        end else if (dec) begin
            if (d == '0) begin
                q      = limit;
                borrow = 1'b1;
            end else begin
                q = d - bcd_digit_t'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_counter_3d.sv
// 3-digit BCD up/down counter with prescaler, sync clear and checked parallel load.
// Owns the count shown by the downstream multiplexed 7-segment scanner.
module bcd_counter_3d
    import d7s_pkg::*;
#(
    parameter int    TICK_DIV = 10_000_000,
    parameter bcd3_t MAX_BCD  = 12'h999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        up_dn,
    input  logic        clr,
    input  logic        load,
    input  logic [11:0] load_val,
    output logic [11:0] bcd,
    output logic        tick,
    output logic        wrap,
    output logic        load_err
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]       presc;
    logic                step;
    logic                load_ok;
    logic                at_limit;
    bcd3_t               chain_q;
    bcd3_t               next_bcd;
    logic [BCD_DIGITS:0] inc_c;
    logic [BCD_DIGITS:0] dec_c;

    assign inc_c[0] = up_dn;
    assign dec_c[0] = ~up_dn;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .d      (bcd[4*i +: 4]),
            .inc    (inc_c[i]),
            .dec    (dec_c[i]),
            .limit  (DIGIT_MAX),
            .q      (chain_q[4*i +: 4]),
            .carry  (inc_c[i+1]),
            .borrow (dec_c[i+1])
        );
    end

    // The wrap limit may sit below 999, so up-wrap compares against MAX_BCD as well as chain overflow.
    assign at_limit = up_dn ? ((bcd == MAX_BCD) || inc_c[BCD_DIGITS]) : dec_c[BCD_DIGITS];
    assign next_bcd = at_limit ? (up_dn ? bcd3_t'(0) : MAX_BCD) : chain_q;
    assign step     = en && (presc == PRE_LAST);
    assign load_ok  = is_valid_bcd(load_val) && (load_val <= MAX_BCD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd      <= '0;
            presc    <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads pre-edge state regardless of statement order.
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                bcd   <= '0;
                presc <= '0;
            end else if (load && load_ok) begin
                bcd   <= load_val;
                presc <= '0;
            end else begin
                load_err <= load;
                if (step) begin
                    presc <= '0;
                    bcd   <= next_bcd;
                    tick  <= 1'b1;
                    wrap  <= at_limit;
                end else if (en) begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_3d.sv
// Self-checking bench for bcd_counter_3d: directed scenarios plus randomized traffic
// compared against a decimal-integer reference model of the counter.
module tb_bcd_counter_3d;

    localparam int TD   = 4;
    localparam int MAXV = 999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, up_dn, clr, load;
    logic [11:0] load_val;
    logic [11:0] bcd, bcd2;
    logic        tick, wrap, load_err;
    logic        tick2, wrap2, load_err2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: count as a plain decimal integer.
    int   m_val, m_pre;
    logic m_tick, m_wrap, m_err;

    bcd_counter_3d #(.TICK_DIV(TD), .MAX_BCD(12'h999)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .bcd(bcd), .tick(tick), .wrap(wrap), .load_err(load_err)
    );

    bcd_counter_3d #(.TICK_DIV(TD), .MAX_BCD(12'h059)) dut59 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .bcd(bcd2), .tick(tick2), .wrap(wrap2), .load_err(load_err2)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(logic [11:0] x);
        return int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic bit load_ok(logic [11:0] x, int maxv);
        if (x[11:8] > 4'd9 || x[7:4] > 4'd9 || x[3:0] > 4'd9) return 1'b0;
        return from_bcd(x) <= maxv;
    endfunction

    task automatic model_reset();
        m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_edge();
        m_tick = 0; m_wrap = 0; m_err = 0;
        if (clr) begin
            m_val = 0; m_pre = 0;
        end else if (load && load_ok(load_val, MAXV)) begin
            m_val = from_bcd(load_val); m_pre = 0;
        end else begin
            if (load) m_err = 1;
            if (en) begin
                if (m_pre == TD - 1) begin
                    m_pre  = 0;
                    m_tick = 1;
                    if (up_dn) begin
                        m_wrap = (m_val == MAXV);
                        m_val  = m_wrap ? 0 : m_val + 1;
                    end else begin
                        m_wrap = (m_val == 0);
                        m_val  = m_wrap ? MAXV : m_val - 1;
                    end
                end else begin
                    m_pre++;
                end
            end
        end
    endtask

    // One clock edge: update the model with the inputs the DUT sampled, then settle.
    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; up_dn = 1; clr = 0; load = 0; load_val = '0;
    endtask

    task automatic do_clear();
        clr = 1; advance(); clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #12;
        n_tests++;
        if ({bcd, tick, wrap, load_err} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_state: got bcd=%h t=%b w=%b e=%b, want 000/0/0/0", bcd, tick, wrap, load_err);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_count_up();
        int ticks = 0;
        en = 1; up_dn = 1;
        for (int i = 0; i < 40; i++) begin
            advance();
            n_tests++;
            if (tick !== ((i % 4) == 3) || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL count_up_tick[%0d]: got t=%b w=%b, want t=%b w=0", i, tick, wrap, (i % 4) == 3);
            end
            n_tests++;
            if (bcd !== to_bcd(m_val) || bcd[3:0] > 4'd9) begin
                n_fail++;
                $display("FAIL count_up_bcd[%0d]: got %h, want %h", i, bcd, to_bcd(m_val));
            end
            if (tick === 1'b1) ticks++;
        end
        n_tests++;
        if (bcd !== 12'h010 || ticks != 10) begin
            n_fail++;
            $display("FAIL count_up_end: got bcd=%h ticks=%0d, want 010 ticks=10", bcd, ticks);
        end
    endtask

    // Load a start value, then collect the next three stepped values and wrap flags.
    task automatic run_three_steps(input logic [11:0] start, input logic dir,
                                   input logic [35:0] exp_vals, input logic [2:0] exp_wraps,
                                   input string name);
        int seen = 0;
        logic [11:0] ev;
        en = 1; up_dn = dir; load = 1; load_val = start;
        advance();
        load = 0;
        for (int i = 0; i < 20 && seen < 3; i++) begin
            advance();
            if (tick === 1'b1) begin
                ev = exp_vals[35 - 12*seen -: 12];
                n_tests++;
                if (bcd !== ev || wrap !== exp_wraps[2 - seen]) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got bcd=%h w=%b, want %h w=%b", name, seen, bcd, wrap, ev, exp_wraps[2 - seen]);
                end
                seen++;
            end
        end
        n_tests++;
        if (seen != 3) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d ticks, want 3", name, seen);
        end
    endtask

    task automatic test_wrap_up();
        run_three_steps(12'h998, 1'b1, {12'h999, 12'h000, 12'h001}, 3'b010, "wrap_up");
    endtask

    task automatic test_wrap_down();
        run_three_steps(12'h000, 1'b0, {12'h999, 12'h998, 12'h997}, 3'b100, "wrap_down");
    endtask

    task automatic test_load_err();
        en = 0; load = 1; load_val = 12'h456;
        advance();
        load_val = 12'h1A3;
        advance();
        n_tests++;
        if (load_err !== 1'b1 || bcd !== 12'h456) begin
            n_fail++;
            $display("FAIL load_err_pulse: got e=%b bcd=%h, want e=1 bcd=456", load_err, bcd);
        end
        load = 0;
        advance();
        n_tests++;
        if (load_err !== 1'b0 || bcd !== 12'h456) begin
            n_fail++;
            $display("FAIL load_err_single: got e=%b bcd=%h, want e=0 bcd=456", load_err, bcd);
        end
        load = 1; load_val = 12'h1A3; clr = 1;
        advance();
        load = 0; clr = 0;
        n_tests++;
        if (load_err !== 1'b0 || bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL clr_over_load: got e=%b bcd=%h, want e=0 bcd=000", load_err, bcd);
        end
        // Load on the step edge: load wins and no tick follows.
        en = 1; up_dn = 1;
        for (int i = 0; i < TD - 1; i++) advance();
        load = 1; load_val = 12'h321;
        advance();
        load = 0;
        n_tests++;
        if (bcd !== 12'h321 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL load_over_step: got bcd=%h t=%b, want 321 t=0", bcd, tick);
        end
        for (int i = 0; i < TD; i++) advance();
        n_tests++;
        if (bcd !== 12'h322 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL step_after_load: got bcd=%h t=%b, want 322 t=1", bcd, tick);
        end
    endtask

    task automatic test_pause();
        do_clear();
        en = 1; up_dn = 1;
        advance(); advance();
        en = 0;
        for (int i = 0; i < 10; i++) begin
            advance();
            n_tests++;
            if (tick !== 1'b0 || bcd !== 12'h000) begin
                n_fail++;
                $display("FAIL pause_hold[%0d]: got t=%b bcd=%h, want t=0 bcd=000", i, tick, bcd);
            end
        end
        en = 1;
        advance();
        n_tests++;
        if (tick !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_early: got t=%b after 1 clk, want 0", tick);
        end
        advance();
        n_tests++;
        if (tick !== 1'b1 || bcd !== 12'h001) begin
            n_fail++;
            $display("FAIL resume_tick: got t=%b bcd=%h after 2 clk, want t=1 bcd=001", tick, bcd);
        end
    endtask

    task automatic test_max59();
        int seen = 0;
        do_clear();
        en = 1; up_dn = 1; load = 1; load_val = 12'h058;
        advance();
        load = 0;
        n_tests++;
        if (bcd2 !== 12'h058 || load_err2 !== 1'b0) begin
            n_fail++;
            $display("FAIL max59_load: got bcd=%h e=%b, want 058 e=0", bcd2, load_err2);
        end
        for (int i = 0; i < 12 && seen < 2; i++) begin
            advance();
            if (tick2 === 1'b1) begin
                n_tests++;
                if (bcd2 !== (seen == 0 ? 12'h059 : 12'h000) || wrap2 !== (seen == 1)) begin
                    n_fail++;
                    $display("FAIL max59_step[%0d]: got bcd=%h w=%b, want %h w=%b", seen, bcd2, wrap2,
                             (seen == 0 ? 12'h059 : 12'h000), seen == 1);
                end
                seen++;
            end
        end
        n_tests++;
        if (seen != 2 || bcd !== to_bcd(m_val)) begin
            n_fail++;
            $display("FAIL max59_end: got ticks=%0d main bcd=%h, want 2 ticks main bcd=%h", seen, bcd, to_bcd(m_val));
        end
        load = 1; load_val = 12'h060;
        advance();
        load = 0;
        n_tests++;
        if (load_err2 !== 1'b1 || bcd2 !== 12'h000) begin
            n_fail++;
            $display("FAIL max59_reject: got e=%b bcd=%h, want e=1 bcd=000", load_err2, bcd2);
        end
    endtask

    task automatic test_async_reset();
        int found = 0;
        en = 1; up_dn = 1; load = 1; load_val = 12'h122;
        advance();
        load = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            advance();
            if (tick === 1'b1) found = 1;
        end
        n_tests++;
        if (found == 0 || bcd !== 12'h123) begin
            n_fail++;
            $display("FAIL async_setup: got bcd=%h tick_seen=%0d, want 123 seen", bcd, found);
        end
        #2;
        rst_n = 0;
        #1;
        n_tests++;
        if ({bcd, tick, wrap, load_err} !== 15'h0) begin
            n_fail++;
            $display("FAIL async_reset: got bcd=%h t=%b w=%b e=%b, want 000/0/0/0", bcd, tick, wrap, load_err);
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        for (int i = 0; i < TD; i++) advance();
        n_tests++;
        if (tick !== 1'b1 || bcd !== 12'h001) begin
            n_fail++;
            $display("FAIL after_reset_step: got t=%b bcd=%h, want t=1 bcd=001", tick, bcd);
        end
    endtask

    task automatic test_random();
        logic [11:0] near [4];
        near[0] = 12'h998; near[1] = 12'h999; near[2] = 12'h000; near[3] = 12'h001;
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            up_dn = $urandom_range(0, 1);
            clr   = ($urandom_range(0, 49) == 0);
            load  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       load_val = to_bcd($urandom_range(0, 999));
                1:       load_val = near[$urandom_range(0, 3)];
                default: load_val = 12'($urandom);
            endcase
            advance();
            n_tests++;
            if (bcd !== to_bcd(m_val) || tick !== m_tick || wrap !== m_wrap || load_err !== m_err) begin
                n_fail++;
                $display("FAIL random[%0d]: got bcd=%h t=%b w=%b e=%b, want bcd=%h t=%b w=%b e=%b",
                         i, bcd, tick, wrap, load_err, to_bcd(m_val), m_tick, m_wrap, m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_err();
        test_pause();
        test_max59();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
